i2s_sample_fifo: RTL and testbench
==================================

I2S_SAMPLE_FIFO -- requirements
Module: i2s_sample_fifo

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 16, meaning the number of stereo frames stored; legal values are powers of two from 2 to 256.
REQ-002 The block SHALL expose the following ports, one per line:
- clk_i  input  1  sole clock; all state updates on its rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- left_i  input  24  signed left sample from the I2S capture stage.
- right_i  input  24  signed right sample from the I2S capture stage.
- valid_i  input  1  one-cycle pulse; the left_i/right_i pair is a complete frame.
- left_o  output  24  signed left sample of the head frame.
- right_o  output  24  signed right sample of the head frame.
- valid_o  output  1  head frame present (FIFO not empty).
- ready_i  input  1  consumer accepts the head frame.
- level_o  output  $clog2(DEPTH)+1  number of frames stored, 0..DEPTH.
- overflow_o  output  1  sticky flag: at least one frame was dropped.
- clear_ovf_i  input  1  one-cycle pulse; clears overflow_o and ovf_count_o.
- ovf_count_o  output  16  count of dropped frames, saturating.

Function
REQ-003 The block SHALL be a first-word-fall-through FIFO of {left, right} 48-bit frames with one clock and no combinational path from valid_i to any output.
REQ-004 Push: the block SHALL write {left_i, right_i} at the rising edge where valid_i=1 and the FIFO is not full, or is full with a pop in the same cycle.
REQ-005 Pop: the block SHALL advance the head at the rising edge where valid_o=1 and ready_i=1.
REQ-006 valid_o SHALL be 1 exactly when level_o is nonzero; left_o/right_o SHALL show the head frame whenever valid_o=1 and SHALL keep the last head contents while empty.
REQ-007 Latency: a frame pushed into an empty FIFO at edge N SHALL appear on left_o/right_o with valid_o=1 in the cycle after edge N.
REQ-008 Push with pop on an empty FIFO: the block SHALL perform only the push, since valid_o=0; level_o becomes 1.
REQ-009 Push with pop on a full FIFO: the block SHALL perform both; level_o stays DEPTH and overflow_o is unchanged.
REQ-010 Push with pop at any other level: the block SHALL perform both and leave level_o unchanged.
REQ-011 Push on a full FIFO without a pop: the block SHALL drop the new frame, keep the stored contents intact, and set overflow_o to 1 at that edge.
REQ-012 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without corrupting data.
REQ-013 level_o SHALL be +1 after a push only, -1 after a pop only, and unchanged after both or neither.
REQ-014 clear_ovf_i SHALL clear overflow_o at the next edge.
REQ-015 If clear_ovf_i and a drop occur in the same cycle, the drop SHALL win: overflow_o=1 afterwards.
REQ-016 Output samples SHALL be bit-exact copies of the inputs, with no sign extension, truncation or reordering.

Reset
REQ-017 While rst_ni=0, the block SHALL immediately force: pointers 0, level_o 0, valid_o 0, left_o/right_o 24'h000000 (storage cleared), overflow_o 0, ovf_count_o 0.
REQ-018 Reset asserted mid-operation SHALL discard all stored frames.
REQ-019 The first push SHALL be accepted at the first rising edge after rst_ni deasserts.

Configuration
REQ-020 With macro I2S_FIFO_OVF_CNT_EN defined, ovf_count_o SHALL increment by 1 on each dropped frame and saturate at 16'hFFFF.
REQ-021 With I2S_FIFO_OVF_CNT_EN defined, clear_ovf_i SHALL zero ovf_count_o; on a simultaneous drop the count SHALL become 1.
REQ-022 Without I2S_FIFO_OVF_CNT_EN, ovf_count_o SHALL be constant 0 and no counter logic SHALL be built; overflow_o behaviour is unchanged.

Verification
REQ-023 Push (L=24'h000001, R=24'hFFFFFF), ready_i=0 -> next cycle valid_o=1, left_o=24'h000001, right_o=24'hFFFFFF, level_o=1.
REQ-024 DEPTH=16, 17 pushes with ready_i=0 -> level_o=16, overflow_o=1, ovf_count_o=1 (macro on), then 16 pops return frames 1..16 in order.
REQ-025 Fill to 16, then push and pop in the same cycle -> level_o=16, overflow_o=0, head advances, new frame appears as the 16th frame out.
REQ-026 20 push/pop pairs through DEPTH=4 -> pointers wrap, output sequence equals input sequence, level_o never exceeds 1.
REQ-027 Drop and clear_ovf_i in the same cycle -> overflow_o=1, ovf_count_o=1; a later lone clear_ovf_i -> both 0.
REQ-028 Assert rst_ni=0 asynchronously with level_o=5 -> outputs zero immediately, level_o=0; after release, a push is visible one cycle later.

Source files
------------

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo
// First-word-fall-through FIFO of stereo I2S frames. Each entry holds one
// {left, right} pair of 24-bit signed samples (48 bits). Single clock domain,
// asynchronous active-low reset that clears pointers, level, storage and
// overflow state.
//
// Parameters
//   DEPTH        number of stereo frames stored (power of two, 2..256)
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   left_i       left sample from the capture stage
//   right_i      right sample from the capture stage
//   valid_i      one-cycle pulse, left_i/right_i form a complete frame
//   left_o       left sample of the head frame
//   right_o      right sample of the head frame
//   valid_o      head frame present (FIFO not empty)
//   ready_i      consumer accepts the head frame
//   level_o      number of frames stored, 0..DEPTH
//   overflow_o   sticky flag, at least one frame was dropped
//   clear_ovf_i  one-cycle pulse, clears overflow_o and ovf_count_o
//   ovf_count_o  saturating count of dropped frames
//
// Configuration
//   I2S_FIFO_OVF_CNT_EN  when defined, builds the 16-bit dropped-frame
//                        counter; otherwise ovf_count_o is tied to zero.

module i2s_sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [23:0]                left_i,
  input  logic [23:0]                right_i,
  input  logic                       valid_i,
  output logic [23:0]                left_o,
  output logic [23:0]                right_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  input  logic                       clear_ovf_i,
  output logic [15:0]                ovf_count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [47:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;

  logic             notEmpty;
  logic             full;
  logic             doPop;
  logic             doPush;
  logic             doDrop;
  logic [PTR_W-1:0] headIdx;

  // A push is allowed into a full FIFO only when the head leaves in the
  // same cycle; a pop needs a frame to be present.
  always_comb begin
    notEmpty = (level_q != '0);
    full     = (level_q == LVL_W'(DEPTH));
    doPop    = notEmpty && ready_i;
    doPush   = valid_i && (!full || doPop);
    doDrop   = valid_i && full && !doPop;
  end

  // Next-state for pointers, level and the sticky overflow flag.
  // Pointers are PTR_W bits wide, so the +1 wraps DEPTH-1 -> 0 naturally.
  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPush && !doPop) begin
      level_d = level_q + LVL_W'(1);
    end else if (doPop && !doPush) begin
      level_d = level_q - LVL_W'(1);
    end
    if (doDrop) begin
      overflow_d = 1'b1;
    end else if (clear_ovf_i) begin
      overflow_d = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage. Cleared on reset so the outputs read zero immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doPush) begin
      mem_q[wrPtr_q] <= {left_i, right_i};
    end
  end

  // While empty, the slot just behind the read pointer still holds the
  // last frame that was popped (writes only land at the read pointer while
  // empty), so showing it keeps the outputs stable without a separate
  // holding register. Right after reset that slot is zero.
  always_comb begin
    headIdx = notEmpty ? rdPtr_q : (rdPtr_q - PTR_W'(1));
  end

  assign left_o     = mem_q[headIdx][47:24];
  assign right_o    = mem_q[headIdx][23:0];
  assign valid_o    = notEmpty;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

`ifdef I2S_FIFO_OVF_CNT_EN
  logic [15:0] ovfCount_q, ovfCount_d;

  // A drop coinciding with a clear restarts the count at one; otherwise
  // the count saturates at all ones.
  always_comb begin
    ovfCount_d = ovfCount_q;
    if (doDrop) begin
      if (clear_ovf_i) begin
        ovfCount_d = 16'd1;
      end else if (ovfCount_q != 16'hFFFF) begin
        ovfCount_d = ovfCount_q + 16'd1;
      end
    end else if (clear_ovf_i) begin
      ovfCount_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovfCount_q <= '0;
    end else begin
      ovfCount_q <= ovfCount_d;
    end
  end

  assign ovf_count_o = ovfCount_q;
`else
  assign ovf_count_o = '0;
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb_i2s_sample_fifo
// Self-checking bench for i2s_sample_fifo (DEPTH=16). A queue-based model of
// the FIFO, overflow flag and drop counter predicts every output; directed
// scenarios cover latency, fill/overflow, full push+pop, wrap-around,
// drop-vs-clear and mid-operation reset, followed by randomized traffic.

module tb_i2s_sample_fifo;

  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [23:0]       leftIn = '0;
  logic [23:0]       rightIn = '0;
  logic              validIn = 1'b0;
  logic              readyIn = 1'b0;
  logic              clearOvf = 1'b0;
  logic [23:0]       leftOut;
  logic [23:0]       rightOut;
  logic              validOut;
  logic [LVL_W-1:0]  levelOut;
  logic              overflowOut;
  logic [15:0]       ovfCountOut;

  logic [47:0] modelQ[$];
  logic [47:0] lastHead = '0;
  logic        modelOvf = 1'b0;
  int          modelCnt = 0;

  int assertCount = 0;
  int failCount = 0;

  i2s_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .left_i      (leftIn),
    .right_i     (rightIn),
    .valid_i     (validIn),
    .left_o      (leftOut),
    .right_o     (rightOut),
    .valid_o     (validOut),
    .ready_i     (readyIn),
    .level_o     (levelOut),
    .overflow_o  (overflowOut),
    .clear_ovf_i (clearOvf),
    .ovf_count_o (ovfCountOut)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] expectedCount();
`ifdef I2S_FIFO_OVF_CNT_EN
    return 64'(modelCnt);
`else
    return 64'd0;
`endif
  endfunction

  // Compare all outputs against the model's view of the FIFO.
  task automatic checkAll(input string tag);
    logic [47:0] head;
    head = (modelQ.size() > 0) ? modelQ[0] : lastHead;
    checkOutput({tag, ".valid"},    64'(validOut),    64'(modelQ.size() > 0));
    checkOutput({tag, ".level"},    64'(levelOut),    64'(modelQ.size()));
    checkOutput({tag, ".left"},     64'(leftOut),     64'(head[47:24]));
    checkOutput({tag, ".right"},    64'(rightOut),    64'(head[23:0]));
    checkOutput({tag, ".overflow"}, 64'(overflowOut), 64'(modelOvf));
    checkOutput({tag, ".ovfcount"}, 64'(ovfCountOut), expectedCount());
  endtask

  task automatic modelReset();
    modelQ.delete();
    lastHead = '0;
    modelOvf = 1'b0;
    modelCnt = 0;
  endtask

  // Behavioural update for one rising edge, from the FIFO rules directly.
  task automatic modelStep(input logic v, input logic [23:0] l, input logic [23:0] r,
                           input logic rdy, input logic clr);
    bit wasFull, pop, push, drop;
    wasFull = (modelQ.size() == DEPTH);
    pop  = (modelQ.size() > 0) && rdy;
    push = v && (!wasFull || pop);
    drop = v && wasFull && !pop;
    if (pop) lastHead = modelQ.pop_front();
    if (push) modelQ.push_back({l, r});
    if (drop) begin
      modelOvf = 1'b1;
      if (clr) modelCnt = 1;
      else if (modelCnt < 65535) modelCnt++;
    end else if (clr) begin
      modelOvf = 1'b0;
      modelCnt = 0;
    end
  endtask

  // Drive one cycle from a negedge, let the edge happen, check at the next negedge.
  task automatic applyStimulus(input string tag, input logic v, input logic [23:0] l,
                               input logic [23:0] r, input logic rdy, input logic clr);
    validIn = v;
    leftIn = l;
    rightIn = r;
    readyIn = rdy;
    clearOvf = clr;
    @(posedge clk);
    modelStep(v, l, r, rdy, clr);
    @(negedge clk);
    validIn = 1'b0;
    readyIn = 1'b0;
    clearOvf = 1'b0;
    checkAll(tag);
  endtask

  task automatic doReset();
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("reset");
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic fillFrames(input int n);
    for (int i = 1; i <= n; i++) begin
      applyStimulus("fill", 1'b1, 24'(i), 24'h800000 | 24'(i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    int vPct, rPct;
    #2;
    checkAll("reset_init");
    @(negedge clk);
    rstN = 1'b1;

    // First push after reset, ready low: visible the next cycle.
    applyStimulus("first_push", 1'b1, 24'h000001, 24'hFFFFFF, 1'b0, 1'b0);
    applyStimulus("pop_one", 1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus("empty_hold", 1'b0, '0, '0, 1'b1, 1'b0);
    applyStimulus("push_pop_empty", 1'b1, 24'h123456, 24'hABCDEF, 1'b1, 1'b0);

    // Seventeen pushes into DEPTH=16 drop the last one, then drain in order.
    doReset();
    fillFrames(DEPTH + 1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("drain", 1'b0, '0, '0, 1'b1, 1'b0);
    end

    // Full FIFO with simultaneous push and pop.
    doReset();
    fillFrames(DEPTH);
    applyStimulus("full_push_pop", 1'b1, 24'h7FFFFF, 24'h800000, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus("drain2", 1'b0, '0, '0, 1'b1, 1'b0);
    end

    // Streaming push/pop pairs wrap both pointers; level stays at most 1.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("stream", 1'b1, 24'($urandom), 24'($urandom), 1'b1, 1'b0);
      checkOutput("stream.levelmax", 64'(levelOut <= 1), 64'd1);
    end

    // Drop and clear in the same cycle, then a lone clear.
    doReset();
    fillFrames(DEPTH);
    applyStimulus("drop_and_clear", 1'b1, 24'hAAAAAA, 24'h555555, 1'b0, 1'b1);
    applyStimulus("drop_again", 1'b1, 24'hBBBBBB, 24'h444444, 1'b0, 1'b0);
    applyStimulus("lone_clear", 1'b0, '0, '0, 1'b0, 1'b1);

    // Asynchronous reset with five frames stored, away from any edge.
    doReset();
    fillFrames(5);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("async_reset");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus("post_reset_push", 1'b1, 24'h00ABCD, 24'hF00001, 1'b0, 1'b0);

    // Randomized traffic with varying pressure to reach empty and full.
    for (int phase = 0; phase < 4; phase++) begin
      case (phase)
        0: begin vPct = 50; rPct = 50; end
        1: begin vPct = 90; rPct = 20; end
        2: begin vPct = 20; rPct = 90; end
        default: begin vPct = 70; rPct = 60; end
      endcase
      for (int i = 0; i < 400; i++) begin
        applyStimulus("random",
                      $urandom_range(99) < vPct,
                      24'($urandom), 24'($urandom),
                      $urandom_range(99) < rPct,
                      $urandom_range(31) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
